// File: rtl/can_tx_mbox_arb_pkg.sv
// Shared types for the CAN transmit mailbox arbiter: frame type, FSM states and
// the arbitration key builder.
package can_pkg;

    localparam int KEY_W = 30;

    typedef enum logic [1:0] {
        FT_DATA,
        FT_REMOTE,
        FT_ERROR,
        FT_OVERLOAD
    } xmitFrameType;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } can_state_t;

    // Mirrors CAN bus arbitration: base id, then IDE bit, then extended id bits.
    function automatic logic [KEY_W-1:0] prio_key(input logic [28:0] id, input logic fmt);
        return {id[28:18], fmt, fmt ? id[17:0] : 18'h0};
    endfunction

endpackage

// File: rtl/can_tx_mbox_arb_prio_sel.sv
// Combinational minimum-key selector across all valid mailboxes.
// Ties resolve to the lowest index.
module can_prio_sel
    import can_pkg::*;
#(
    parameter int NUM_MBOX = 4,
    parameter int IDX_W    = $clog2(NUM_MBOX)
) (
    input  logic [NUM_MBOX-1:0]       i_valid,
    input  logic [NUM_MBOX*KEY_W-1:0] i_keys,
    output logic [IDX_W-1:0]          o_idx,
    output logic                      o_valid
);

    logic [KEY_W-1:0] w_best_key;

    always_comb begin
        o_valid    = 1'b0;
        o_idx      = '0;
        w_best_key = '1;
        for (int i = 0; i < NUM_MBOX; i++) begin
            // Strict less-than keeps the earlier (lower) index on a tie.
            if (i_valid[i] && (!o_valid || (i_keys[i*KEY_W +: KEY_W] < w_best_key))) begin
                o_valid    = 1'b1;
                o_idx      = IDX_W'(i);
                w_best_key = i_keys[i*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/can_tx_mbox_arb.sv
// CAN transmit mailbox bank with priority arbitration and a start/done handshake
// towards the bit-level transmitter.
module can_tx_mbox_arb
    import can_pkg::*;
#(
    parameter int NUM_MBOX      = 4,
    parameter int START_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_MBOX)-1:0] wr_sel,
    input  logic [28:0]                 wr_id,
    input  logic                        wr_format,
    input  logic [3:0]                  wr_datalen,
    input  logic [63:0]                 wr_data,
    input  xmitFrameType                wr_frametype,
    input  logic [NUM_MBOX-1:0]         abort_mask,
    output logic [NUM_MBOX-1:0]         pending,
    output logic                        wr_err,
    output logic                        tx_done,
    output logic                        tx_fail,
    output logic [$clog2(NUM_MBOX)-1:0] tx_idx,
    output logic                        startXmit,
    output logic [63:0]                 xmitdata,
    output logic [3:0]                  datalen,
    output logic [28:0]                 id,
    output logic                        format,
    output xmitFrameType                frameType,
    input  logic                        busy
);

    localparam int IDX_W = $clog2(NUM_MBOX);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    logic [28:0]  r_mb_id   [NUM_MBOX];
    logic         r_mb_fmt  [NUM_MBOX];
    logic [3:0]   r_mb_len  [NUM_MBOX];
    logic [63:0]  r_mb_data [NUM_MBOX];
    xmitFrameType r_mb_ft   [NUM_MBOX];

    logic [NUM_MBOX-1:0] r_pending;
    can_state_t          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_start;
    logic                r_wr_err;
    logic                r_tx_done;
    logic                r_tx_fail;
    logic [IDX_W-1:0]    r_tx_idx;
    logic [63:0]         r_xmitdata;
    logic [3:0]          r_datalen;
    logic [28:0]         r_id;
    logic                r_format;
    xmitFrameType        r_frame_type;

    logic [NUM_MBOX*KEY_W-1:0] w_keys;
    logic [IDX_W-1:0]          w_win_idx;
    logic                      w_win_vld;
    logic                      w_fly_vld;
    logic [IDX_W-1:0]          w_fly_idx;
    logic [NUM_MBOX-1:0]       w_fly_vec;
    logic                      w_wr_ok;
    logic                      w_wr_err;

    always_comb begin
        w_keys = '0;
        for (int i = 0; i < NUM_MBOX; i++) begin
            w_keys[i*KEY_W +: KEY_W] = prio_key(r_mb_id[i], r_mb_fmt[i]);
        end
    end

    can_prio_sel #(
        .NUM_MBOX (NUM_MBOX),
        .IDX_W    (IDX_W)
    ) u_prio_sel (
        .i_valid (r_pending),
        .i_keys  (w_keys),
        .o_idx   (w_win_idx),
        .o_valid (w_win_vld)
    );

    // The winner being captured in IDLE is already treated as in flight.
    always_comb begin
        w_fly_vld = (r_state != IDLE) || w_win_vld;
        w_fly_idx = (r_state == IDLE) ? w_win_idx : r_idx;
        w_fly_vec = '0;
        for (int i = 0; i < NUM_MBOX; i++) begin
            w_fly_vec[i] = w_fly_vld && (w_fly_idx == IDX_W'(i));
        end
        w_wr_ok  = wr_en && (int'(wr_sel) < NUM_MBOX) && !(w_fly_vld && (wr_sel == w_fly_idx));
        w_wr_err = wr_en && !w_wr_ok;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mb_id[wr_sel]   <= wr_id;
            r_mb_fmt[wr_sel]  <= wr_format;
            r_mb_len[wr_sel]  <= (wr_datalen > 4'd8) ? 4'd8 : wr_datalen;
            r_mb_data[wr_sel] <= wr_data;
            r_mb_ft[wr_sel]   <= wr_frametype;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_start      <= 1'b0;
            r_wr_err     <= 1'b0;
            r_tx_done    <= 1'b0;
            r_tx_fail    <= 1'b0;
            r_tx_idx     <= '0;
            r_xmitdata   <= '0;
            r_datalen    <= '0;
            r_id         <= '0;
            r_format     <= 1'b0;
            r_frame_type <= FT_DATA;
        end else begin
            r_wr_err  <= w_wr_err;
            r_tx_done <= 1'b0;
            r_tx_fail <= 1'b0;

            for (int i = 0; i < NUM_MBOX; i++) begin
                if (!w_fly_vec[i]) begin
                    if (w_wr_ok && (wr_sel == IDX_W'(i))) begin
                        r_pending[i] <= 1'b1;
                    end else if (abort_mask[i]) begin
                        r_pending[i] <= 1'b0;
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_win_vld) begin
                        r_idx        <= w_win_idx;
                        r_id         <= r_mb_id[w_win_idx];
                        r_format     <= r_mb_fmt[w_win_idx];
                        r_datalen    <= r_mb_len[w_win_idx];
                        r_xmitdata   <= r_mb_data[w_win_idx];
                        r_frame_type <= r_mb_ft[w_win_idx];
                        r_state      <= START;
                    end
                end
                START: begin
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        r_start <= 1'b0;
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_start   <= 1'b0;
                        r_tx_fail <= 1'b1;
                        r_tx_idx  <= r_idx;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        r_pending[r_idx] <= 1'b0;
                        r_tx_done        <= 1'b1;
                        r_tx_idx         <= r_idx;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pending   = r_pending;
    assign wr_err    = r_wr_err;
    assign tx_done   = r_tx_done;
    assign tx_fail   = r_tx_fail;
    assign tx_idx    = r_tx_idx;
    assign startXmit = r_start;
    assign xmitdata  = r_xmitdata;
    assign datalen   = r_datalen;
    assign id        = r_id;
    assign format    = r_format;
    assign frameType = r_frame_type;

endmodule

// File: tb/tb_can_tx_mbox_arb.sv
// Randomized and directed bench for can_tx_mbox_arb against a mailbox-level model
// that orders frames by CAN arbitration rules.
module tb_can_tx_mbox_arb;
    import can_pkg::*;

    typedef struct packed {
        logic [28:0] id;
        logic        fmt;
        logic [3:0]  len;
        logic [63:0] data;
        logic [1:0]  ft;
    } mb_t;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [1:0]   wr_sel;
    logic [28:0]  wr_id;
    logic         wr_format;
    logic [3:0]   wr_datalen;
    logic [63:0]  wr_data;
    xmitFrameType wr_frametype;
    logic [3:0]   abort_mask;
    logic [3:0]   pending;
    logic         wr_err;
    logic         tx_done;
    logic         tx_fail;
    logic [1:0]   tx_idx;
    logic         startXmit;
    logic [63:0]  xmitdata;
    logic [3:0]   datalen;
    logic [28:0]  id;
    logic         format;
    xmitFrameType frameType;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mb_t        mdl [4];
    logic [3:0] mpend;

    can_tx_mbox_arb #(
        .NUM_MBOX      (4),
        .START_TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_id        (wr_id),
        .wr_format    (wr_format),
        .wr_datalen   (wr_datalen),
        .wr_data      (wr_data),
        .wr_frametype (wr_frametype),
        .abort_mask   (abort_mask),
        .pending      (pending),
        .wr_err       (wr_err),
        .tx_done      (tx_done),
        .tx_fail      (tx_fail),
        .tx_idx       (tx_idx),
        .startXmit    (startXmit),
        .xmitdata     (xmitdata),
        .datalen      (datalen),
        .id           (id),
        .format       (format),
        .frameType    (frameType),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mb_t mk(input logic [28:0] i, input logic f, input logic [3:0] l,
                               input logic [63:0] d, input logic [1:0] t);
        mb_t m;
        m.id = i; m.fmt = f; m.len = l; m.data = d; m.ft = t;
        return m;
    endfunction

    function automatic mb_t rand_mb();
        logic [28:0] base;
        case ($urandom_range(0, 2))
            0:       base = 29'h100 << 18;
            1:       base = 29'h101 << 18;
            default: base = 29'h200 << 18;
        endcase
        return mk(base | 29'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    endfunction

    // CAN arbitration order: 11-bit base id, then standard before extended, then low id bits.
    function automatic longint unsigned key_of(input mb_t m);
        longint unsigned k;
        k = longint'(m.id / (1 << 18)) * (1 << 19);
        if (m.fmt) k = k + (1 << 18) + longint'(m.id % (1 << 18));
        return k;
    endfunction

    function automatic int winner();
        int best;
        best = -1;
        for (int i = 0; i < 4; i++) begin
            if (mpend[i] && (best < 0 || key_of(mdl[i]) < key_of(mdl[best]))) best = i;
        end
        return best;
    endfunction

    task automatic model_write(input int sel, input mb_t m);
        mdl[sel] = m;
        if (m.len > 4'd8) mdl[sel].len = 4'd8;
        mpend[sel] = 1'b1;
    endtask

    task automatic drive_wr(input int sel, input mb_t m);
        wr_en        = 1'b1;
        wr_sel       = 2'(sel);
        wr_id        = m.id;
        wr_format    = m.fmt;
        wr_datalen   = m.len;
        wr_data      = m.data;
        wr_frametype = xmitFrameType'(m.ft);
    endtask

    task automatic do_write(input int sel, input mb_t m, input logic exp_err);
        drive_wr(sel, m);
        @(negedge clk);
        wr_en = 1'b0;
        check_val("wr_err", wr_err, exp_err);
        if (!exp_err) model_write(sel, m);
    endtask

    task automatic do_abort(input logic [3:0] mask, input int fly);
        abort_mask = mask;
        @(negedge clk);
        abort_mask = '0;
        for (int i = 0; i < 4; i++) if (mask[i] && i != fly) mpend[i] = 1'b0;
    endtask

    task automatic check_fields(input string tag, input mb_t e);
        check_val({tag, "_id"}, id, e.id);
        check_val({tag, "_fmt"}, format, e.fmt);
        check_val({tag, "_len"}, datalen, e.len);
        check_val({tag, "_data"}, xmitdata, e.data);
        check_val({tag, "_ft"}, frameType, e.ft);
    endtask

    task automatic wait_start();
        for (int k = 0; k < 300; k++) begin
            if (startXmit) break;
            @(negedge clk);
        end
        check_val("start_seen", startXmit, 1'b1);
    endtask

    // Acts as the transmitter up to WAIT_DONE, asserting busy dly cycles into startXmit.
    task automatic serve_start(input mb_t e, input int dly);
        int hi;
        wait_start();
        check_fields("start", e);
        hi = 1;
        repeat (dly - 1) begin
            @(negedge clk);
            if (startXmit) hi++;
        end
        busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!startXmit) break;
            hi++;
        end
        check_val("start_len", hi, dly);
    endtask

    task automatic serve_finish(input int idx, input mb_t e, input int hold);
        repeat (hold) @(negedge clk);
        check_fields("hold", e);
        busy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_done) break;
        end
        check_val("tx_done", tx_done, 1'b1);
        check_val("tx_idx", tx_idx, idx);
        mpend[idx] = 1'b0;
    endtask

    task automatic serve(input int idx, input int dly, input int hold);
        serve_start(mdl[idx], dly);
        serve_finish(idx, mdl[idx], hold);
    endtask

    initial begin
        int hi;
        int first;
        int n;
        int w;
        int ord [4];
        int t;
        int j;

        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_id = '0; wr_format = 1'b0;
        wr_datalen = '0; wr_data = '0; wr_frametype = FT_DATA; abort_mask = '0; busy = 1'b0;
        mpend = '0;
        repeat (3) @(negedge clk);
        check_val("rst_pending", pending, 0);
        check_val("rst_start", startXmit, 0);
        check_val("rst_outs", {xmitdata, datalen, id, format}, 0);
        check_val("rst_ft", frameType, FT_DATA);
        check_val("rst_pulses", {wr_err, tx_done, tx_fail, tx_idx}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame on mailbox 2.
        do_write(2, mk(29'h123 << 18, 1'b0, 4'd3, 64'hAABBCC0000000000, 2'd0), 1'b0);
        serve(2, 2, 40);
        check_val("pend_after_2", pending, mpend);

        // Lower base id wins even when written later.
        do_write(1, mk(29'h7FF << 18, 1'b0, 4'd1, 64'h11, 2'd1), 1'b0);
        serve_start(mdl[1], 1);
        do_write(0, mk(29'h200 << 18, 1'b0, 4'd2, 64'h22, 2'd0), 1'b0);
        do_write(3, mk(29'h100 << 18, 1'b0, 4'd4, 64'h33, 2'd2), 1'b0);
        serve_finish(1, mdl[1], 2);
        serve(3, 1, 1);
        serve(0, 3, 1);

        // Standard beats extended with the same base id.
        do_write(2, mk(29'h7FF << 18, 1'b1, 4'd0, 64'h44, 2'd3), 1'b0);
        serve_start(mdl[2], 2);
        do_write(0, mk(29'h100 << 18, 1'b1, 4'd8, 64'h55, 2'd0), 1'b0);
        do_write(1, mk(29'h100 << 18, 1'b0, 4'd8, 64'h66, 2'd1), 1'b0);
        serve_finish(2, mdl[2], 1);
        serve(1, 1, 1);
        serve(0, 1, 1);

        // In-flight write rejected, in-flight abort ignored, pending abort honoured.
        do_write(1, mk(29'h050 << 18, 1'b0, 4'd5, 64'h77, 2'd0), 1'b0);
        serve_start(mdl[1], 2);
        do_write(1, mk(29'h001 << 18, 1'b1, 4'd7, 64'h88, 2'd2), 1'b1);
        do_abort(4'b0010, 1);
        check_val("abort_fly", pending, mpend);
        do_write(0, mk(29'h000, 1'b0, 4'd1, 64'h99, 2'd0), 1'b0);
        do_abort(4'b0001, 1);
        check_val("abort_pend", pending, mpend);
        drive_wr(2, mk(29'h060 << 18, 1'b0, 4'd2, 64'hAA, 2'd1));
        abort_mask = 4'b0100;
        @(negedge clk);
        wr_en = 1'b0; abort_mask = '0;
        model_write(2, mk(29'h060 << 18, 1'b0, 4'd2, 64'hAA, 2'd1));
        check_val("wr_beats_abort", pending, mpend);
        serve_finish(1, mdl[1], 3);
        serve(2, 1, 1);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (startXmit) hi++;
        end
        check_val("aborted_never_sent", hi, 0);
        check_val("pend_idle", pending, 0);

        // Start timeout, then retry of the same mailbox with clamped length.
        do_write(3, mk(29'h0AB << 18, 1'b0, 4'd12, 64'hBB, 2'd0), 1'b0);
        wait_start();
        check_val("clamp_len", datalen, 4'd8);
        hi = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_fail) break;
            if (startXmit) hi++;
        end
        check_val("tx_fail", tx_fail, 1'b1);
        check_val("timeout_len", hi, 255);
        check_val("fail_idx", tx_idx, 3);
        check_val("fail_start_low", startXmit, 1'b0);
        check_val("fail_pending", pending, 4'b1000);
        @(negedge clk);
        check_val("fail_pulse", tx_fail, 1'b0);
        serve(3, 1, 1);

        // Reset mid-frame.
        do_write(0, mk(29'h0CD << 18, 1'b1, 4'd6, 64'hCC, 2'd3), 1'b0);
        serve_start(mdl[0], 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_outs", {pending, startXmit, xmitdata, datalen, id, format}, 0);
        check_val("mid_rst_pulses", {wr_err, tx_done, tx_fail, tx_idx, frameType}, 0);
        rst = 1'b0; busy = 1'b0; mpend = '0;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_done || tx_fail || startXmit) hi++;
        end
        check_val("mid_rst_quiet", hi, 0);

        // Randomized bursts written while one frame is in flight.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) ord[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            n = $urandom_range(2, 4);
            first = ord[0];
            do_write(first, rand_mb(), 1'b0);
            serve_start(mdl[first], $urandom_range(1, 3));
            for (int k = 1; k < n; k++) do_write(ord[k], rand_mb(), 1'b0);
            if ($urandom_range(0, 1) == 1) do_write(first, rand_mb(), 1'b1);
            do_abort(4'($urandom_range(0, 15)), first);
            check_val("rnd_pend", pending, mpend);
            serve_finish(first, mdl[first], $urandom_range(0, 4));
            for (int k = 0; k < 4; k++) begin
                if (mpend == 0) break;
                w = winner();
                serve(w, $urandom_range(1, 3), $urandom_range(0, 3));
            end
            check_val("rnd_drain", pending, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
